// File: rtl/parity_stream.sv
`default_nettype none
// ============================================================================
// parity_stream : frame parity generator/checker with saturating beat count.
// Optional macro PARITY_STREAM_ERR_CNT_EN adds a 16-bit err_cnt output.
// Revision      : 1.0
// ============================================================================
module parity_stream #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8,
  parameter int ODD   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             in_abort,
  input  logic             chk_en,
  input  logic             chk_bit,
  output logic             par_valid,
  output logic             par_out,
  output logic             par_err,
  output logic [CNT_W-1:0] frame_len,
`ifdef PARITY_STREAM_ERR_CNT_EN
  output logic [15:0]      err_cnt,
`endif
  output logic             busy
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  localparam logic             c_odd     = (ODD != 0);
  localparam logic [CNT_W-1:0] c_cnt_max = '1;

  state_t           state_q, state_d;
  logic             acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             par_valid_q, par_valid_d;
  logic             par_out_q, par_out_d;
  logic             par_err_q, par_err_d;
  logic [CNT_W-1:0] frame_len_q, frame_len_d;

  logic             beat_par;
  logic             acc_next;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    beat_par = ^in_data;
    // The first beat of a frame starts fresh instead of folding into stale acc.
    if (state_q == IDLE) begin
      acc_next = beat_par;
      cnt_next = CNT_W'(1);
    end else begin
      acc_next = acc_q ^ beat_par;
      cnt_next = (cnt_q == c_cnt_max) ? cnt_q : cnt_q + CNT_W'(1);
    end

    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    par_valid_d = 1'b0;
    par_err_d   = 1'b0;
    par_out_d   = par_out_q;
    frame_len_d = frame_len_q;

    if (in_abort) begin
      state_d = IDLE;
      acc_d   = 1'b0;
      cnt_d   = '0;
    end else if (in_valid) begin
      if (in_last) begin
        state_d     = IDLE;
        acc_d       = 1'b0;
        cnt_d       = '0;
        par_valid_d = 1'b1;
        par_out_d   = acc_next ^ c_odd;
        par_err_d   = chk_en & (chk_bit != (acc_next ^ c_odd));
        frame_len_d = cnt_next;
      end else begin
        state_d = ACCUM;
        acc_d   = acc_next;
        cnt_d   = cnt_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= 1'b0;
      cnt_q       <= '0;
      par_valid_q <= 1'b0;
      par_out_q   <= 1'b0;
      par_err_q   <= 1'b0;
      frame_len_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      par_valid_q <= par_valid_d;
      par_out_q   <= par_out_d;
      par_err_q   <= par_err_d;
      frame_len_q <= frame_len_d;
    end
  end

  assign par_valid = par_valid_q;
  assign par_out   = par_out_q;
  assign par_err   = par_err_q;
  assign frame_len = frame_len_q;
  assign busy      = (state_q == ACCUM);

`ifdef PARITY_STREAM_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Counts alongside the strobe so err_cnt already reflects the reported error.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (par_valid_d && par_err_d && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= 16'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule
`default_nettype wire

// File: doc/parity_stream.md
PARITY_STREAM -- requirements
Module: parity_stream

Interface
- REQ-001: Parameter WIDTH, default 8; data word width in bits, minimum 1.
- REQ-002: Parameter CNT_W, default 8; width of the frame beat counter, minimum 1.
- REQ-003: Parameter ODD, default 1; 1 selects odd parity, 0 selects even parity.
- REQ-004: The block SHALL use one clock, clk; reset rst_n is synchronous and active-low.
- REQ-005: clk  input  1  sole clock; all state updates on the rising edge.
- REQ-006: rst_n  input  1  synchronous active-low reset.
- REQ-007: in_valid  input  1  beat qualifier.
- REQ-008: in_data  input  WIDTH  beat data.
- REQ-009: in_last  input  1  marks the final beat of a frame; valid only with in_valid.
- REQ-010: in_abort  input  1  discards the open frame.
- REQ-011: chk_en  input  1  enables the check against chk_bit; sampled on the last beat.
- REQ-012: chk_bit  input  1  received parity bit; sampled on the last beat.
- REQ-013: par_valid  output  1  one-cycle result strobe.
- REQ-014: par_out  output  1  generated frame parity.
- REQ-015: par_err  output  1  check mismatch flag, qualified by par_valid.
- REQ-016: frame_len  output  CNT_W  beats in the completed frame, saturating.
- REQ-017: busy  output  1  high while a frame is open.

Function
- REQ-018: The block SHALL have two states: IDLE (no frame open) and ACCUM (frame open); busy SHALL be 1 only in ACCUM.
- REQ-019: Each accepted beat SHALL update acc as acc XOR (reduction-XOR of in_data); the first beat of a frame SHALL load acc from that beat alone, with no XOR against the previous value.
- REQ-020: Transitions:
  - IDLE with valid and not last -> ACCUM.
  - IDLE with valid and last -> IDLE, and the one-beat frame completes.
  - ACCUM with valid and last -> IDLE, and the frame completes.
  - ACCUM with in_valid low -> ACCUM; all state is held.
- REQ-021: Completion latency SHALL be one cycle.
  - In the cycle after the last beat, par_valid=1 for exactly one cycle.
  - par_out = final_acc XOR ODD.
  - frame_len = beat count including the last beat.
- REQ-022: par_err SHALL equal chk_en AND (chk_bit != par_out), using chk_en and chk_bit as sampled on the last beat; par_err SHALL be 0 whenever par_valid=0.
- REQ-023: Back-to-back frames SHALL be accepted with no bubble; a beat in the cycle after a last beat starts a new frame while the previous result is being presented.
- REQ-024: The beat counter SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap; parity accumulation continues past saturation.
- REQ-025: Abort behaviour:
  - in_abort=1 SHALL return the block to IDLE and clear acc and the beat count.
  - No par_valid is generated for the aborted frame.
  - Abort takes priority over a simultaneous beat, including a last beat; that beat is discarded.
- REQ-026: in_abort in IDLE with in_valid=0 SHALL have no effect.
- REQ-027: par_out, par_err and frame_len SHALL hold their values between strobes.

Reset
- REQ-028: With rst_n=0 at a clock edge, the block SHALL enter IDLE, and acc, beat count, par_valid, par_out, par_err, frame_len and busy SHALL all be 0.
- REQ-029: Reset during ACCUM SHALL discard the open frame with no par_valid; the first beat after reset release starts a new frame.

Configuration
- REQ-030: With macro PARITY_STREAM_ERR_CNT_EN defined, the block SHALL add output err_cnt (16 bits).
  - err_cnt increments on each cycle with par_valid=1 and par_err=1.
  - err_cnt saturates at 16'hFFFF.
  - Reset value is 0.
- REQ-031: With PARITY_STREAM_ERR_CNT_EN undefined, the err_cnt port and its logic SHALL be absent; all other behaviour is unchanged.

Verification (WIDTH=8, ODD=1 unless stated)
- REQ-032: Single beat 8'h00 with last, chk_en=0 -> next cycle par_valid=1, par_out=1, par_err=0, frame_len=1.
- REQ-033: Beats 8'h01, 8'h03, 8'h07 (last on the third), with 3 idle cycles between beats 1 and 2 -> par_out=1, frame_len=3, busy=1 throughout the gap; with ODD=0 -> par_out=0.
- REQ-034: 8'hFF with last, chk_en=1, chk_bit=0 -> par_out=1, par_err=1, and err_cnt 0->1 when the macro is defined; then chk_bit=1 on the same data -> par_err=0.
- REQ-035: Frame 8'h01, 8'h01 with in_abort on the second beat, then 8'h01 with last -> exactly one par_valid strobe, par_out=0, frame_len=1.
- REQ-036: Back-to-back single-beat frames 8'h01 then 8'h03 on consecutive cycles -> par_valid high two consecutive cycles, par_out 0 then 1.
- REQ-037: With CNT_W=2, a 5-beat frame of 8'h00 -> frame_len=3, par_out=1; rst_n=0 asserted mid-frame -> all outputs 0 and no strobe.
